// File: rtl/serial_frame_deser.sv
// rtl/serial_frame_deser.sv - sync-hunting serial-to-parallel frame deserializer
//
// Purpose: hunts the incoming serial bit stream for SYNC_PAT, then assembles
// FRAME_WORDS words of WIDTH bits (MSB first) and presents each one on a
// valid/ready output register. A word that completes while the previous one
// is still unconsumed is dropped and flagged in the sticky overflow bit.
//
// Ports:
//   sclk        in   clock, all state updates on posedge
//   rst         in   synchronous active-high reset
//   din         in   serial data, one bit per sclk
//   word_out    out  [WIDTH-1:0] assembled data word
//   word_valid  out  word_out holds an unconsumed word
//   word_ready  in   consumer accepts word_out when word_valid is high
//   sync_locked out  high while collecting data words after a sync match
//   overflow    out  sticky, a completed word was dropped
//   frame_cnt   out  [7:0] sync match count, wraps modulo 256
module serial_frame_deser #(
    parameter int                  SYNC_LEN    = 8,
    parameter logic [SYNC_LEN-1:0] SYNC_PAT    = 'hB4,
    parameter int                  WIDTH       = 8,
    parameter int                  FRAME_WORDS = 4
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             din,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             sync_locked,
    output logic             overflow,
    output logic [7:0]       frame_cnt
);

    localparam int BCW = $clog2(WIDTH);
    localparam int WCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(FRAME_WORDS - 1);

    typedef enum logic {
        HUNT,
        COLLECT
    } state_e;

    state_e state_q, state_d;

    // Only the low bits of each shift register are ever read: the oldest bit
    // is shifted out in the same edge that the full pattern/word is formed,
    // so the registers keep one bit less than the pattern/word length.
    logic [SYNC_LEN-2:0] hunt_sr_q, hunt_sr_d;
    logic [WIDTH-2:0]    data_sr_q, data_sr_d;
    logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WCW-1:0]      word_cnt_q, word_cnt_d;
    logic [WIDTH-1:0]    word_out_q, word_out_d;
    logic                word_valid_q, word_valid_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;

    logic [SYNC_LEN-1:0] hunt_next;
    logic [WIDTH-1:0]    data_next;
    logic                word_done;

    assign hunt_next = {hunt_sr_q, din};
    assign data_next = {data_sr_q, din};

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q      <= HUNT;
            hunt_sr_q    <= '0;
            data_sr_q    <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            hunt_sr_q    <= hunt_sr_d;
            data_sr_q    <= data_sr_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            overflow_q   <= overflow_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hunt_sr_d    = hunt_sr_q;
        data_sr_d    = data_sr_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        word_out_d   = word_out_q;
        word_valid_d = word_valid_q;
        overflow_d   = overflow_q;
        frame_cnt_d  = frame_cnt_q;
        word_done    = 1'b0;

        case (state_q)
            HUNT: begin
                hunt_sr_d = hunt_next[SYNC_LEN-2:0];
                if (hunt_next == SYNC_PAT) begin
                    state_d     = COLLECT;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    bit_cnt_d   = '0;
                    word_cnt_d  = '0;
                end
            end
            COLLECT: begin
                data_sr_d = data_next[WIDTH-2:0];
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BIT_LAST) begin
                    word_done  = 1'b1;
                    bit_cnt_d  = '0;
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == WORD_LAST) begin
                        // Clearing the hunt register guarantees the tail of
                        // the data can never combine with new bits into a sync.
                        state_d    = HUNT;
                        hunt_sr_d  = '0;
                        word_cnt_d = '0;
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        // A completing word may load while the old one is being accepted in
        // the same edge; in that case valid simply stays high.
        if (word_done) begin
            if (!word_valid_q || word_ready) begin
                word_out_d   = data_next;
                word_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (word_valid_q && word_ready) begin
            word_valid_d = 1'b0;
        end
    end

    assign word_out    = word_out_q;
    assign word_valid  = word_valid_q;
    assign sync_locked = (state_q == COLLECT);
    assign overflow    = overflow_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
